// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and sizing constants for the fetch queue
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int FQ_DEPTH   = 4;
  localparam int FQ_CNT_W   = $clog2(FQ_DEPTH + 1);
  localparam int FQ_A_WIDTH = 32;
  localparam int FQ_I_WIDTH = 32;

  typedef struct packed {
    logic [FQ_I_WIDTH-1:0] instr;
    logic [FQ_A_WIDTH-1:0] pc;
    logic [FQ_A_WIDTH-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fq_ctrl.sv
// ============================================================================
// fq_ctrl : pointer/occupancy control for fetch_queue, flush has priority
// Revision : 1.0
// ============================================================================
`default_nettype none

module fq_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic                       out_ready,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic                       push,
  output logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Full/empty come from count alone; pointer equality is ambiguous.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : show-ahead circular prefetch buffer between fetch and decode
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int A_WIDTH = FQ_A_WIDTH,
  parameter int I_WIDTH = FQ_I_WIDTH,
  parameter int DEPTH   = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [I_WIDTH-1:0]         in_instr,
  input  logic [A_WIDTH-1:0]         in_pc,
  input  logic [A_WIDTH-1:0]         in_pc_plus4,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [I_WIDTH-1:0]         out_instr,
  output logic [A_WIDTH-1:0]         out_pc,
  output logic [A_WIDTH-1:0]         out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [I_WIDTH-1:0] mem_instr    [DEPTH];
  logic [A_WIDTH-1:0] mem_pc       [DEPTH];
  logic [A_WIDTH-1:0] mem_pc_plus4 [DEPTH];

  fq_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count)
  );

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr]    <= in_instr;
      mem_pc[wr_ptr]       <= in_pc;
      mem_pc_plus4[wr_ptr] <= in_pc_plus4;
    end
  end

  always_comb begin
    out_instr    = '0;
    out_pc       = '0;
    out_pc_plus4 = '0;
    if (out_valid) begin
      out_instr    = mem_instr[rd_ptr];
      out_pc       = mem_pc[rd_ptr];
      out_pc_plus4 = mem_pc_plus4[rd_ptr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : directed and random checks of fetch_queue vs a queue model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;
  import fetch_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [31:0]         in_instr = '0;
  logic [31:0]         in_pc = '0;
  logic [31:0]         in_pc_plus4 = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [31:0]         out_instr;
  logic [31:0]         out_pc;
  logic [31:0]         out_pc_plus4;
  logic [FQ_CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;

  fetch_entry_t model_q[$];

  fetch_queue #(
    .A_WIDTH (32),
    .I_WIDTH (32),
    .DEPTH   (FQ_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_pc_plus4  (in_pc_plus4),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the reference queue's contents.
  task automatic check_outputs(input string tag);
    fetch_entry_t head;
    head = '0;
    if (model_q.size() != 0) head = model_q[0];
    chk({tag, ".count"},     32'(count),     32'(model_q.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(model_q.size() != FQ_DEPTH));
    chk({tag, ".out_pc"},    out_pc,         head.pc);
    chk({tag, ".out_instr"}, out_instr,      head.instr);
    chk({tag, ".out_p4"},    out_pc_plus4,   head.pc_plus4);
  endtask

  // Reference behaviour at a rising edge: flush wins, a full queue refuses
  // pushes even when popping, an empty queue ignores out_ready.
  task automatic model_edge();
    bit do_push;
    bit do_pop;
    fetch_entry_t e;
    if (flush) begin
      model_q.delete();
    end else begin
      do_push = in_valid && (model_q.size() < FQ_DEPTH);
      do_pop  = out_ready && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.instr    = in_instr;
        e.pc       = in_pc;
        e.pc_plus4 = in_pc_plus4;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic step(input string tag, input logic f, input logic iv,
                      input logic rdy, input logic [31:0] pc);
    check_outputs(tag);
    flush       = f;
    in_valid    = iv;
    out_ready   = rdy;
    in_pc       = pc;
    in_pc_plus4 = pc + 32'd4;
    in_instr    = $urandom;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    // Reset then idle
    repeat (2) @(negedge clk);
    check_outputs("rst_hold");
    rst = 1'b1;
    step("idle0", 0, 0, 0, 32'h0);
    step("idle1", 0, 0, 0, 32'h0);
    chk("idle_out_pc", out_pc, 32'h0);

    // Fill and drain
    for (int i = 0; i < 4; i++) step("fill", 0, 1, 0, 32'(i * 4));
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    step("push5", 0, 1, 0, 32'h10);
    chk("push5_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'(i * 4));
      step("drain", 0, 0, 1, 32'h0);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Streaming through pointer wrap with one entry buffered
    step("stream_seed", 0, 1, 0, 32'h100);
    for (int i = 0; i < 10; i++) begin
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_lag", out_pc, 32'h100 + 32'(i * 4));
      step("stream", 0, 1, 1, 32'h104 + 32'(i * 4));
    end
    step("stream_end", 0, 0, 1, 32'h0);

    // Full with simultaneous pop
    for (int i = 0; i < 4; i++) step("refill", 0, 1, 0, 32'h200 + 32'(i * 4));
    step("full_pop", 0, 1, 1, 32'h20);
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_ready", 32'(in_ready), 32'd1);
    step("retry", 0, 1, 0, 32'h20);
    chk("retry_count", 32'(count), 32'd4);

    // Flush priority over push and pop
    step("pre_flush", 0, 0, 1, 32'h0);
    chk("pre_flush_count", 32'(count), 32'd3);
    step("flush", 1, 1, 1, 32'h40);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step("flush_hold", 1, 1, 0, 32'h44);
    step("post_flush", 0, 1, 0, 32'h80);
    chk("post_flush_pc", out_pc, 32'h80);
    step("post_flush_pop", 0, 0, 1, 32'h0);
    chk("post_flush_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges
    step("ar_a", 0, 1, 0, 32'h300);
    step("ar_b", 0, 1, 0, 32'h304);
    chk("ar_pre_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    model_q.delete();
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    check_outputs("ar_async");
    @(negedge clk);
    rst = 1'b1;
    step("ar_push", 0, 1, 0, 32'h400);
    chk("ar_first_pc", out_pc, 32'h400);

    // Random traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 400; i++) begin
      logic f;
      logic iv;
      logic rdy;
      f = ($urandom_range(0, 24) == 0);
      if ((i / 50) % 2 == 0) begin
        iv  = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) == 0);
      end else begin
        iv  = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 3) != 0);
      end
      step("rand", f, iv, rdy, $urandom);
    end
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer placed directly downstream of the fetch stage and upstream of decode in the pipelined core.
- Captures each fetched instruction with its pc and pc_plus4 into a small circular FIFO.
- Presents the oldest entry to decode through a valid/ready handshake.
- A flush from branch/jump resolution discards all buffered entries.

Parameters:
A_WIDTH, 32, width of pc and pc_plus4
I_WIDTH, 32, instruction width
DEPTH, 4, number of entries; power of two, at least 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-low
flush  input  1  discard all entries (taken branch/jump redirect)
in_valid  input  1  fetch presents an entry this cycle
in_ready  output  1  queue can accept an entry this cycle
in_instr  input  I_WIDTH  instruction from instruction memory
in_pc  input  A_WIDTH  pc of in_instr
in_pc_plus4  input  A_WIDTH  pc + 4 of in_instr
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_instr  output  I_WIDTH  head instruction
out_pc  output  A_WIDTH  head pc
out_pc_plus4  output  A_WIDTH  head pc + 4
count  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Reset (rst low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0. Outputs while reset is held: out_valid = 0, in_ready = 1, out_* = 0. Storage array is not reset.
- Push: in_valid && in_ready at a rising edge writes the entry at wr_ptr and increments wr_ptr modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge increments rd_ptr modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- in_ready = (count != DEPTH), combinational from registered state. A full queue does not accept a push even if a pop occurs in the same cycle.
- out_valid = (count != 0). out_instr, out_pc and out_pc_plus4 show the entry at rd_ptr (show-ahead) when out_valid = 1, and read as 0 when empty.
- Latency: an entry pushed at edge N is visible on the outputs after edge N, so decode can pop it at edge N+1. There is no same-cycle bypass from the in_* ports to the out_* ports.
- Empty: out_ready is ignored and the pointers do not move.
- Full: in_valid is ignored. Fetch must hold its pc; the queue applies no backpressure other than in_ready.
- flush has priority over push and pop in the same cycle:
  - wr_ptr, rd_ptr and count go to 0 at the edge.
  - The in_* entry presented in that cycle is dropped.
  - Any pop in that cycle is suppressed.
  - After the edge: out_valid = 0 and in_ready = 1.
  - flush held high for several cycles keeps the queue empty.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is decided by count, never by pointer equality.
- Reset mid-operation: every buffered entry is lost. The first push after release goes to slot 0.
- Entry contents are stored unmodified; the queue does not check pc_plus4 == pc + 4.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t = struct {instr, pc, pc_plus4}
  - constants FQ_DEPTH = 4 and FQ_CNT_W = $clog2(FQ_DEPTH+1)
- One natural sub-module, fq_ctrl: owns wr_ptr, rd_ptr, count, flush priority, and generation of in_ready/out_valid.
- The storage array and output muxing stay in fetch_queue.

Test Plan:
- Reset then idle: rst low for 2 cycles, then high, with no stimulus -> out_valid = 0, in_ready = 1, count = 0, out_pc = 0.
- Fill and drain: push pc = 0x00, 0x04, 0x08, 0x0C with out_ready = 0 -> count = 4 and in_ready = 0. A 5th push of pc = 0x10 is ignored. Then assert out_ready -> out_pc sequence 0x00, 0x04, 0x08, 0x0C on consecutive cycles, then out_valid = 0.
- Streaming: continuous push and pop starting from 1 buffered entry -> count stays 1. out_pc lags in_pc by one cycle. Run 10 entries to exercise pointer wrap; all pc values come out in order.
- Full with simultaneous pop: count = 4, in_valid = 1 (pc = 0x20), out_ready = 1 -> pop occurs, push rejected, count = 3. On the next cycle in_ready = 1 and pc = 0x20 is accepted.
- Flush priority: count = 3, then flush = 1 with in_valid = 1 (pc = 0x40) and out_ready = 1 -> after the edge count = 0 and out_valid = 0. The next push of pc = 0x80 appears as out_pc = 0x80; 0x40 never appears.
- Async reset mid-stream: pull rst low between clock edges while count = 2 -> out_valid = 0 and count = 0 immediately, with no clock edge required.
